mini_sequencer: RTL and testbench

Program sequencer that sits directly upstream of `mini_processor`. It holds a small loadable instruction store, and on `start` it issues each instruction's operands and opcode to the ALU. It then captures the ALU `result` back, streams one result per instruction, and keeps a running 4-bit checksum. It turns the combinational ALU into a self-running, cycle-deterministic datapath that a bench or board top can drive with one handshake.

---
 rtl/mini_sequencer.sv | 124 ++++++++++++
 tb/tb_mini_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_sequencer.sv
// mini_sequencer: loadable instruction store that drives the mini_processor ALU,
// captures each result and keeps a running 4-bit checksum.
module mini_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [10:0]   load_data,
    input  logic          start,
    input  logic [3:0]    prog_len,
    output logic [3:0]    A,
    output logic [3:0]    B,
    output logic [1:0]    ctrl,
    input  logic [3:0]    alu_result,
    output logic          busy,
    output logic          res_valid,
    output logic [3:0]    res_data,
    output logic [AW-1:0] res_index,
    output logic [3:0]    checksum,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] pc;
    logic [4:0]    len;
    logic [4:0]    req_len;
    logic [10:0]   word;
    logic          last;

    // len needs one bit more than prog_len so DEPTH = 16 still fits
    always_comb begin
        req_len = {1'b0, prog_len};
        if (req_len > 5'(DEPTH)) begin
            req_len = 5'(DEPTH);
        end
        word = mem[pc];
        last = (5'(pc) == len - 5'd1);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (req_len == 5'd0) ? DONE : FETCH;
                end
            end
            FETCH: state_nx = EXEC;
            EXEC:  state_nx = last ? DONE : FETCH;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            len       <= '0;
            A         <= '0;
            B         <= '0;
            ctrl      <= '0;
            res_data  <= '0;
            res_index <= '0;
            checksum  <= '0;
            res_valid <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state     <= state_nx;
            res_valid <= 1'b0;
            // done trails the DONE state by one cycle so it never meets res_valid
            done      <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (load_en) begin
                        mem[load_addr] <= load_data;
                    end
                    if (start) begin
                        len      <= req_len;
                        pc       <= '0;
                        checksum <= '0;
                        res_data <= '0;
                    end
                end
                FETCH: begin
                    A    <= word[10] ? res_data : word[7:4];
                    B    <= word[3:0];
                    ctrl <= word[9:8];
                end
                EXEC: begin
                    res_data  <= alu_result;
                    res_index <= pc;
                    checksum  <= checksum + alu_result;
                    res_valid <= 1'b1;
                    if (!last) begin
                        pc <= pc + 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mini_sequencer.sv
// tb_mini_sequencer: drives mini_sequencer against a behavioural ALU and
// checks every run against a program-level reference model.
module tb_mini_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int NCYC  = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [10:0]   load_data;
    logic          start;
    logic [3:0]    prog_len;
    logic [3:0]    A;
    logic [3:0]    B;
    logic [1:0]    ctrl;
    logic [3:0]    alu_result;
    logic          busy;
    logic          res_valid;
    logic [3:0]    res_data;
    logic [AW-1:0] res_index;
    logic [3:0]    checksum;
    logic          done;

    int vectors = 0;
    int miscompares = 0;

    mini_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start), .prog_len(prog_len),
        .A(A), .B(B), .ctrl(ctrl), .alu_result(alu_result),
        .busy(busy), .res_valid(res_valid), .res_data(res_data),
        .res_index(res_index), .checksum(checksum), .done(done)
    );

    always #5 clk = ~clk;

    // stand-in for mini_processor
    always_comb begin
        alu_result = 4'd0;
        case (ctrl)
            2'b00: alu_result = A + B;
            2'b01: alu_result = A - B;
            2'b10: alu_result = A & B;
            default: alu_result = A | B;
        endcase
    end

    // reference program store and expected results
    logic [10:0] mm [DEPTH];
    logic [3:0]  exp_d[$];
    logic [3:0]  exp_cs;

    // observations of the last run, indexed by edge offset j from the start edge
    int          obs_j[$];
    logic [3:0]  obs_d[$];
    logic [2:0]  obs_i[$];
    int          done_j;
    int          done_cnt;
    logic [3:0]  done_cs;
    logic [3:0]  a_at [NCYC];
    logic        busy_at [NCYC];
    logic [23:0] outs_at [NCYC];

    function automatic void model(input logic [3:0] plen);
        int n;
        logic [3:0] prev, a, b, r;
        n = (int'(plen) > DEPTH) ? DEPTH : int'(plen);
        prev = 4'd0;
        exp_d.delete();
        exp_cs = 4'd0;
        for (int k = 0; k < n; k++) begin
            a = mm[k][10] ? prev : mm[k][7:4];
            b = mm[k][3:0];
            case (mm[k][9:8])
                2'b00: r = a + b;
                2'b01: r = a - b;
                2'b10: r = a & b;
                default: r = a | b;
            endcase
            exp_d.push_back(r);
            exp_cs = exp_cs + r;
            prev = r;
        end
    endfunction

    task automatic load(input int addr, input logic [10:0] data);
        @(negedge clk);
        load_en = 1'b1;
        load_addr = 3'(addr);
        load_data = data;
        @(negedge clk);
        load_en = 1'b0;
        mm[addr] = data;
    endtask

    task automatic load_random();
        for (int i = 0; i < DEPTH; i++) begin
            load(i, 11'($urandom));
        end
    endtask

    task automatic run(input logic [3:0] plen, input bit poke,
                       input bit sim_load, input logic [10:0] sim_data,
                       input int rst_at);
        obs_j.delete();
        obs_d.delete();
        obs_i.delete();
        done_j = -1;
        done_cnt = 0;
        done_cs = 4'd0;
        @(negedge clk);
        start = 1'b1;
        prog_len = plen;
        if (sim_load) begin
            load_en = 1'b1;
            load_addr = '0;
            load_data = sim_data;
        end
        for (int j = 0; j < NCYC; j++) begin
            @(negedge clk);
            a_at[j] = A;
            busy_at[j] = busy;
            outs_at[j] = {A, B, ctrl, res_data, res_index, checksum,
                          busy, res_valid, done};
            if (res_valid) begin
                obs_j.push_back(j);
                obs_d.push_back(res_data);
                obs_i.push_back(res_index);
            end
            if (done) begin
                done_j = j;
                done_cs = checksum;
                done_cnt++;
            end
            start = 1'b0;
            load_en = 1'b0;
            rst = 1'b0;
            if (poke && j == 3) begin
                start = 1'b1;
                prog_len = 4'hF;
                load_en = 1'b1;
                load_addr = 3'($urandom);
                load_data = 11'($urandom);
            end
            if (j == rst_at) begin
                rst = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        start = 1'b0;
        prog_len = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({A, B, ctrl, res_data, res_index, checksum, busy, res_valid, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want 0",
                     {A, B, ctrl, res_data, res_index, checksum, busy, res_valid, done});
        end
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        run(4'd1, 1'b0, 1'b0, '0, -1);
        vectors++;
        if (obs_d.size() != 1 || obs_d[0] !== 4'd0 || obs_j[0] != 2) begin
            miscompares++;
            $display("FAIL reset_run got %0d results want 1 zero result at j=2", obs_d.size());
        end
        vectors++;
        if (done_j != 3 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL reset_run_done got j=%0d cnt=%0d want j=3 cnt=1", done_j, done_cnt);
        end
    endtask

    task automatic test_four_op();
        logic [3:0] want [4];
        want = '{4'b1000, 4'b0100, 4'b1000, 4'b1110};
        load(0, {1'b0, 2'b00, 4'b0101, 4'b0011});
        load(1, {1'b0, 2'b01, 4'b0101, 4'b0001});
        load(2, {1'b0, 2'b10, 4'b1010, 4'b1100});
        load(3, {1'b0, 2'b11, 4'b1010, 4'b1100});
        run(4'd4, 1'b0, 1'b0, '0, -1);
        vectors++;
        if (obs_d.size() != 4) begin
            miscompares++;
            $display("FAIL four_op_count got %0d want 4", obs_d.size());
        end
        for (int k = 0; k < 4 && k < obs_d.size(); k++) begin
            vectors++;
            if (obs_d[k] !== want[k] || obs_i[k] !== 3'(k) || obs_j[k] != 2 * k + 2) begin
                miscompares++;
                $display("FAIL four_op_%0d got d=%b i=%0d j=%0d want d=%b i=%0d j=%0d",
                         k, obs_d[k], obs_i[k], obs_j[k], want[k], k, 2 * k + 2);
            end
        end
        vectors++;
        if (done_cs !== 4'b0010 || done_j != 9) begin
            miscompares++;
            $display("FAIL four_op_done got cs=%b j=%0d want cs=0010 j=9", done_cs, done_j);
        end
    endtask

    task automatic test_chain();
        load(0, {1'b0, 2'b00, 4'b0111, 4'b0110});
        load(1, {1'b1, 2'b00, 4'($urandom), 4'b0101});
        run(4'd2, 1'b0, 1'b0, '0, -1);
        vectors++;
        if (obs_d.size() != 2 || obs_d[0] !== 4'b1101 || obs_d[1] !== 4'b0010) begin
            miscompares++;
            $display("FAIL chain_results got %0d results want 1101,0010", obs_d.size());
        end
        vectors++;
        if (a_at[3] !== 4'b1101) begin
            miscompares++;
            $display("FAIL chain_operand got A=%b want 1101", a_at[3]);
        end
        vectors++;
        if (done_j != 5 || done_cs !== 4'b1111) begin
            miscompares++;
            $display("FAIL chain_done got j=%0d cs=%b want j=5 cs=1111", done_j, done_cs);
        end
    endtask

    task automatic test_len0();
        run(4'd0, 1'b0, 1'b0, '0, -1);
        vectors++;
        if (obs_d.size() != 0 || done_j != 1 || done_cnt != 1 || busy_at[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL len0 got results=%0d done_j=%0d cnt=%0d busy=%b want 0,1,1,1",
                     obs_d.size(), done_j, done_cnt, busy_at[0]);
        end
    endtask

    task automatic test_len12();
        load_random();
        model(4'd12);
        run(4'd12, 1'b0, 1'b0, '0, -1);
        vectors++;
        if (obs_d.size() != DEPTH || done_j != 2 * DEPTH + 1) begin
            miscompares++;
            $display("FAIL len12_count got %0d done_j=%0d want %0d done_j=%0d",
                     obs_d.size(), done_j, DEPTH, 2 * DEPTH + 1);
        end
        for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
            vectors++;
            if (obs_d[k] !== exp_d[k] || obs_i[k] !== 3'(k)) begin
                miscompares++;
                $display("FAIL len12_%0d got d=%h i=%0d want d=%h i=%0d",
                         k, obs_d[k], obs_i[k], exp_d[k], k);
            end
        end
    endtask

    task automatic test_ignored();
        logic [3:0] n;
        load_random();
        n = 4'($urandom_range(3, DEPTH));
        model(n);
        for (int pass = 0; pass < 2; pass++) begin
            run(n, pass == 0, 1'b0, '0, -1);
            vectors++;
            if (obs_d.size() != exp_d.size() || done_cs !== exp_cs || done_cnt != 1) begin
                miscompares++;
                $display("FAIL ignored_%0d got results=%0d cs=%h want %0d cs=%h",
                         pass, obs_d.size(), done_cs, exp_d.size(), exp_cs);
            end
            for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
                vectors++;
                if (obs_d[k] !== exp_d[k]) begin
                    miscompares++;
                    $display("FAIL ignored_%0d_res%0d got %h want %h",
                             pass, k, obs_d[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_simul_load();
        logic [10:0] w;
        logic [3:0]  n;
        load_random();
        w = 11'($urandom);
        n = 4'($urandom_range(1, DEPTH));
        mm[0] = w;
        model(n);
        run(n, 1'b0, 1'b1, w, -1);
        vectors++;
        if (obs_d.size() != exp_d.size() || obs_d.size() == 0 || obs_d[0] !== exp_d[0]) begin
            miscompares++;
            $display("FAIL simul_load got results=%0d first=%h want %0d first=%h",
                     obs_d.size(), obs_d.size() ? obs_d[0] : 4'd0, exp_d.size(), exp_d[0]);
        end
        vectors++;
        if (done_cs !== exp_cs) begin
            miscompares++;
            $display("FAIL simul_load_cs got %h want %h", done_cs, exp_cs);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] n;
        load_random();
        run(4'd5, 1'b0, 1'b0, '0, 5);
        vectors++;
        if (obs_d.size() != 2 || done_j != -1) begin
            miscompares++;
            $display("FAIL reset_mid_abort got results=%0d done_j=%0d want 2,-1",
                     obs_d.size(), done_j);
        end
        vectors++;
        if (outs_at[6] !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs got %h want 0", outs_at[6]);
        end
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        n = 4'($urandom_range(1, DEPTH));
        model(n);
        run(n, 1'b0, 1'b0, '0, -1);
        vectors++;
        if (obs_d.size() != exp_d.size() || done_cs !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mid_rerun got results=%0d cs=%h want %0d cs=0",
                     obs_d.size(), done_cs, exp_d.size());
        end
        for (int k = 0; k < obs_d.size(); k++) begin
            vectors++;
            if (obs_d[k] !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_mid_res%0d got %h want 0", k, obs_d[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] plen;
        int n;
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 1) == 1) load(i, 11'($urandom));
            end
            plen = 4'($urandom);
            model(plen);
            n = exp_d.size();
            run(plen, 1'b0, 1'b0, '0, -1);
            vectors++;
            if (obs_d.size() != n) begin
                miscompares++;
                $display("FAIL random%0d_count got %0d want %0d", it, obs_d.size(), n);
            end
            for (int k = 0; k < obs_d.size() && k < n; k++) begin
                vectors++;
                if (obs_d[k] !== exp_d[k] || obs_i[k] !== 3'(k) || obs_j[k] != 2 * k + 2) begin
                    miscompares++;
                    $display("FAIL random%0d_res%0d got d=%h i=%0d j=%0d want d=%h i=%0d j=%0d",
                             it, k, obs_d[k], obs_i[k], obs_j[k], exp_d[k], k, 2 * k + 2);
                end
            end
            vectors++;
            if (done_j != ((n == 0) ? 1 : 2 * n + 1) || done_cnt != 1 || done_cs !== exp_cs) begin
                miscompares++;
                $display("FAIL random%0d_done got j=%0d cnt=%0d cs=%h want j=%0d cnt=1 cs=%h",
                         it, done_j, done_cnt, done_cs, (n == 0) ? 1 : 2 * n + 1, exp_cs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_four_op();
        test_chain();
        test_len0();
        test_len12();
        test_ignored();
        test_simul_load();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
